// File: rtl/vme_pkg.sv
// Shared VME package: bus signal polarity, arbiter state encodings and level selection helpers,
// plus constants used by the transfer block.
package vme_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_BUSY    = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_e;

    // Transfer block address modifiers and DTACK watchdog length
    localparam logic [5:0] AM_A24_DATA   = 6'h39;
    localparam logic [5:0] AM_A32_DATA   = 6'h09;
    localparam int         DTACK_TIMEOUT = 256;

    function automatic logic [1:0] pri_pick(input logic [3:0] req);
        logic [1:0] sel;
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) sel = 2'(i);
        end
        return sel;
    endfunction

    // Later iterations overwrite earlier ones, so last-1 wins and last itself is the fallback.
    function automatic logic [1:0] rrs_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] sel;
        logic [1:0] lvl;
        sel = last;
        for (int i = 4; i >= 1; i--) begin
            lvl = last - 2'(i);
            if (req[lvl]) sel = lvl;
        end
        return sel;
    endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchronizer for asynchronous bus lines; resets to a chosen idle value.
module vme_sync2 #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta     <= INIT;
            sync_out <= INIT;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/vme_system_arbiter.sv
// VME system controller arbiter: PRI/RRS selection over BR3..BR0 with grant timeout and bus clear.
// state   | meaning
// IDLE    | waiting for a request with the bus free
// GRANT   | one BG driven, waiting for BBSY
// BUSY    | owner holds the bus; BCLR when a higher level waits (PRI)
// RELEASE | one dead cycle with all BG/BCLR inactive
module vme_system_arbiter
    import vme_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arb_mode,
    input  logic [3:0] vme_bus_request,
    input  logic       vme_bbsy,
    output logic [3:0] vme_bus_grant,
    output logic       vme_bclr,
    output logic [1:0] arb_owner,
    output logic [1:0] arb_state,
    output logic       arb_timeout
);

    localparam int               CNT_W    = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    logic [4:0]       sync_bus;
    logic [3:0]       req;
    logic             bbsy;
    logic [3:0]       above_mask;
    arb_state_e       state, state_nxt;
    logic [1:0]       owner_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mode_lat, mode_nxt;
    logic             timeout_nxt;

    vme_sync2 #(
        .WIDTH (5),
        .INIT  ({5{INACTIVE}})
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in ({vme_bbsy, vme_bus_request}),
        .sync_out (sync_bus)
    );

    assign req  = ~sync_bus[3:0];
    assign bbsy = (sync_bus[4] == ACTIVE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            arb_owner   <= 2'd0;
            wait_cnt    <= '0;
            mode_lat    <= 1'b0;
            arb_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            arb_owner   <= owner_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mode_lat    <= mode_nxt;
            arb_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = arb_owner;
        wait_cnt_nxt = '0;
        mode_nxt     = mode_lat;
        timeout_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((|req) && !bbsy) begin
                    owner_nxt = arb_mode ? rrs_pick(req, arb_owner) : pri_pick(req);
                    mode_nxt  = arb_mode;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // BBSY outranks withdrawal, which outranks the timeout
                if (bbsy) begin
                    state_nxt = ST_BUSY;
                end else if (!req[arb_owner]) begin
                    state_nxt = ST_RELEASE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt   = ST_RELEASE;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!bbsy) state_nxt = ST_RELEASE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign above_mask    = 4'b1110 << arb_owner;
    assign vme_bus_grant = (state == ST_GRANT) ? ~(4'b0001 << arb_owner) : {4{INACTIVE}};
    assign vme_bclr      = (state == ST_BUSY && !mode_lat && (|(req & above_mask))) ? ACTIVE : INACTIVE;
    assign arb_state     = state;

endmodule

// File: tb/tb_vme_system_arbiter.sv
// Self-checking bench for vme_system_arbiter: directed scenarios then randomized traffic
// checked against a level-selection model fed from the recorded input history.
module tb_vme_system_arbiter;

    localparam int GT = 8;

    logic       clock;
    logic       reset;
    logic       arb_mode;
    logic [3:0] vme_bus_request;
    logic       vme_bbsy;
    logic [3:0] vme_bus_grant;
    logic       vme_bclr;
    logic [1:0] arb_owner;
    logic [1:0] arb_state;
    logic       arb_timeout;

    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [3:0] h_br   [8192];
    logic       h_bbsy [8192];
    logic       h_mode [8192];

    vme_system_arbiter #(.GRANT_TIMEOUT(GT)) dut (
        .clock           (clock),
        .reset           (reset),
        .arb_mode        (arb_mode),
        .vme_bus_request (vme_bus_request),
        .vme_bbsy        (vme_bbsy),
        .vme_bus_grant   (vme_bus_grant),
        .vme_bclr        (vme_bclr),
        .arb_owner       (arb_owner),
        .arb_state       (arb_state),
        .arb_timeout     (arb_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record what the DUT will sample at the coming edge, then look at results 1 ns after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            h_br[cyc+1]   = vme_bus_request;
            h_bbsy[cyc+1] = vme_bbsy;
            h_mode[cyc+1] = arb_mode;
            @(posedge clock);
            cyc++;
            #1;
        end
    endtask

    task automatic wait_grant(input string tag, output logic [3:0] g);
        for (int i = 0; i < 20; i++) begin
            if (vme_bus_grant !== 4'hF) break;
            step(1);
        end
        chk(tag, 32'(vme_bus_grant !== 4'hF), 32'd1);
        g = vme_bus_grant;
    endtask

    function automatic int bg_level(input logic [3:0] g);
        int r = 0;
        for (int l = 0; l < 4; l++) if (!g[l]) r = l;
        return r;
    endfunction

    // Reference selection: PRI = highest active level; RRS = first active of last-1, last-2, ... mod 4.
    function automatic int model_pick(input logic [3:0] act, input int last, input logic mode);
        int r = -1;
        if (!mode) begin
            for (int l = 3; l >= 0; l--) if (act[l] && r < 0) r = l;
        end else begin
            for (int s = 1; s <= 4; s++) if (act[(last + 4 - s) % 4] && r < 0) r = (last + 4 - s) % 4;
        end
        return r;
    endfunction

    initial begin
        logic [3:0] g;
        logic [3:0] exp_g;
        logic [3:0] one;
        logic [3:0] br_act;
        logic [3:0] prev_bg;
        int         exp_ord [5];
        int         act, last, e, busy_left, mst_lvl, run;

        one     = 4'b0001;
        exp_ord = '{3, 2, 1, 0, 3};

        reset = 1'b0; arb_mode = 1'b0; vme_bus_request = 4'hF; vme_bbsy = 1'b1;
        step(2);
        chk("rst_bg",      32'(vme_bus_grant), 32'hF);
        chk("rst_bclr",    32'(vme_bclr),      32'd1);
        chk("rst_owner",   32'(arb_owner),     32'd0);
        chk("rst_state",   32'(arb_state),     32'd0);
        chk("rst_timeout", 32'(arb_timeout),   32'd0);
        reset = 1'b1;
        step(1);

        // PRI with levels 3 and 1 requesting
        vme_bus_request = 4'b0101;
        step(1); chk("pri_edge1", 32'(vme_bus_grant), 32'hF);
        step(1); chk("pri_edge2", 32'(vme_bus_grant), 32'hF);
        step(1); chk("pri_edge3", 32'(vme_bus_grant), 32'b0111);
        chk("pri_owner", 32'(arb_owner), 32'd3);
        vme_bbsy = 1'b0;
        step(2); chk("pri_bg_hold", 32'(vme_bus_grant), 32'b0111);
        step(1); chk("pri_bg_off", 32'(vme_bus_grant), 32'hF);
        chk("pri_busy", 32'(arb_state), 32'd2);
        chk("pri_no_bclr", 32'(vme_bclr), 32'd1);
        vme_bbsy = 1'b1; vme_bus_request = 4'hF;
        step(3); chk("pri_release", 32'(arb_state), 32'd3);
        step(2); chk("pri_idle", 32'(arb_state), 32'd0);

        // PRI preemption of level 1 by level 3
        vme_bus_request = 4'b1101;
        step(3); chk("pre_bg1", 32'(vme_bus_grant), 32'b1101);
        chk("pre_owner1", 32'(arb_owner), 32'd1);
        vme_bbsy = 1'b0;
        step(3); chk("pre_busy", 32'(arb_state), 32'd2);
        chk("pre_bclr_off", 32'(vme_bclr), 32'd1);
        vme_bus_request = 4'b0101;
        step(3); chk("pre_bclr_on", 32'(vme_bclr), 32'd0);
        vme_bbsy = 1'b1; vme_bus_request = 4'b0111;
        step(2); chk("pre_still_busy", 32'(arb_state), 32'd2);
        step(1); chk("pre_release", 32'(arb_state), 32'd3);
        chk("pre_rel_bclr", 32'(vme_bclr), 32'd1);
        chk("pre_rel_bg", 32'(vme_bus_grant), 32'hF);
        step(1); chk("pre_idle", 32'(arb_state), 32'd0);
        step(1); chk("pre_bg3", 32'(vme_bus_grant), 32'b0111);
        chk("pre_owner3", 32'(arb_owner), 32'd3);

        // Request withdrawn during GRANT
        vme_bus_request = 4'hF;
        step(1); chk("wd_to1", 32'(arb_timeout), 32'd0);
        step(1); chk("wd_to2", 32'(arb_timeout), 32'd0);
        step(1); chk("wd_state", 32'(arb_state), 32'd3);
        chk("wd_to3", 32'(arb_timeout), 32'd0);
        step(1); chk("wd_to4", 32'(arb_timeout), 32'd0);
        step(1);

        // Round robin from reset, all levels requesting
        reset = 1'b0;
        step(1); chk("rrs_rst_owner", 32'(arb_owner), 32'd0);
        reset = 1'b1; arb_mode = 1'b1; vme_bus_request = 4'h0;
        for (int i = 0; i < 5; i++) begin
            wait_grant("rrs_wait", g);
            exp_g = ~(one << exp_ord[i]);
            chk("rrs_order", 32'(g), 32'(exp_g));
            vme_bbsy = 1'b0;
            step(5);
            vme_bbsy = 1'b1;
        end
        reset = 1'b0; arb_mode = 1'b0; vme_bus_request = 4'hF;
        step(1);
        reset = 1'b1;

        // Timeout with BR0 held and no BBSY
        vme_bus_request = 4'b1110;
        wait_grant("to_wait", g);
        chk("to_level", 32'(g), 32'b1110);
        act = 0;
        while (vme_bus_grant !== 4'hF && act < 20) begin
            act++;
            step(1);
        end
        chk("to_len", 32'(act), 32'(GT));
        chk("to_state_rel", 32'(arb_state), 32'd3);
        chk("to_pulse", 32'(arb_timeout), 32'd1);
        step(1);
        chk("to_pulse_end", 32'(arb_timeout), 32'd0);
        chk("to_idle", 32'(arb_state), 32'd0);
        step(1);
        chk("to_regrant", 32'(vme_bus_grant), 32'b1110);

        // Reset while granting
        reset = 1'b0;
        step(1);
        chk("rg_bg", 32'(vme_bus_grant), 32'hF);
        chk("rg_state", 32'(arb_state), 32'd0);
        chk("rg_bclr", 32'(vme_bclr), 32'd1);
        reset = 1'b1;

        // BBSY, timeout and withdrawal all seen on the same edge
        wait_grant("tie_wait", g);
        step(5);
        vme_bbsy = 1'b0; vme_bus_request = 4'hF;
        step(2);
        chk("tie_pre_state", 32'(arb_state), 32'd1);
        step(1);
        chk("tie_state", 32'(arb_state), 32'd2);
        chk("tie_bg", 32'(vme_bus_grant), 32'hF);
        chk("tie_timeout", 32'(arb_timeout), 32'd0);
        vme_bbsy = 1'b1;
        step(6);
        chk("tie_idle", 32'(arb_state), 32'd0);

        // Randomized traffic
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        br_act = 4'h0; busy_left = 0; mst_lvl = 0; last = 0; run = 0; prev_bg = 4'hF;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(63) == 0) arb_mode = ~arb_mode;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    vme_bbsy = 1'b1;
                    if ($urandom_range(1) == 1) br_act[mst_lvl] = 1'b0;
                end
            end else if (vme_bus_grant !== 4'hF && $urandom_range(3) == 0) begin
                busy_left = $urandom_range(6, 2);
                mst_lvl   = bg_level(vme_bus_grant);
                vme_bbsy  = 1'b0;
            end
            for (int l = 0; l < 4; l++) begin
                if (!br_act[l]) br_act[l] = ($urandom_range(3) == 0);
                else if (!(busy_left > 0 && l == mst_lvl) && $urandom_range(15) == 0) br_act[l] = 1'b0;
            end
            vme_bus_request = ~br_act;
            step(1);

            chk("rnd_onehot", 32'($countones(~vme_bus_grant) <= 1), 32'd1);
            if (prev_bg === 4'hF && vme_bus_grant !== 4'hF) begin
                e = model_pick(~h_br[cyc-2], last, h_mode[cyc]);
                exp_g = (e < 0) ? 4'hF : ~(one << e);
                chk("rnd_grant", 32'(vme_bus_grant), 32'(exp_g));
                chk("rnd_owner", 32'(arb_owner), 32'(e));
                chk("rnd_bus_free", 32'(h_bbsy[cyc-2]), 32'd1);
                if (e >= 0) last = e;
                run = 0;
            end
            if (vme_bus_grant !== 4'hF) run++;
            else if (prev_bg !== 4'hF) chk("rnd_grant_len", 32'(run <= GT), 32'd1);
            prev_bg = vme_bus_grant;
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/vme_system_arbiter.md
VME_SYSTEM_ARBITER -- requirements
Module: vme_system_arbiter

Interface
REQ-001 SHALL have parameter GRANT_TIMEOUT, default 64: clock cycles a grant may stay unanswered by BBSY before it is withdrawn.
REQ-002 SHALL have port clock  in  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port arb_mode  in  1  0 = fixed priority (PRI, BR3 highest); 1 = round-robin (RRS).
REQ-005 SHALL have port vme_bus_request  in  4  BR3..BR0, active-low, asynchronous to clock.
REQ-006 SHALL have port vme_bbsy  in  1  bus busy, active-low, asynchronous.
REQ-007 SHALL have port vme_bus_grant  out  4  BG3IN..BG0IN daisy-chain heads, active-low.
REQ-008 SHALL have port vme_bclr  out  1  bus clear, active-low.
REQ-009 SHALL have port arb_owner  out  2  level most recently granted.
REQ-010 SHALL have port arb_state  out  2  current FSM state, for debug.
REQ-011 SHALL have port arb_timeout  out  1  active-high, one-cycle pulse when a grant times out.

Function
REQ-012 SHALL pass vme_bus_request and vme_bbsy through a two-flop synchronizer; all decisions use synchronized values only.
REQ-013 SHALL implement four states: IDLE=00, GRANT=01, BUSY=10, RELEASE=11.
REQ-014 In IDLE, if any synchronized BR is active and synchronized BBSY is inactive, SHALL register the selected level into arb_owner, drive that single BG active, and enter GRANT.
REQ-015 With a stable BR and BBSY inactive from IDLE, BG SHALL be active after the third rising edge following BR first meeting setup.
REQ-016 PRI selection SHALL pick the highest active level (3 over 2 over 1 over 0).
REQ-017 RRS selection SHALL search descending from arb_owner-1 with wrap (3 follows 0), so arb_owner itself is searched last.
REQ-018 No more than one BG SHALL be active at any time; BG SHALL be active only in GRANT.
REQ-019 In GRANT, when synchronized BBSY becomes active, BG SHALL go inactive on the next edge and the FSM SHALL enter BUSY.
REQ-020 In GRANT, a wait counter SHALL count cycles from grant. When the counter reaches GRANT_TIMEOUT-1 with BBSY still inactive, BG SHALL go inactive, arb_timeout SHALL pulse for one cycle, and the FSM SHALL enter RELEASE.
REQ-021 In GRANT, if BR[arb_owner] goes inactive before BBSY, BG SHALL go inactive and the FSM SHALL enter RELEASE, with no timeout pulse.
REQ-022 When BBSY, timeout and request withdrawal occur in the same cycle, BBSY SHALL win and the FSM SHALL enter BUSY.
REQ-023 In BUSY with arb_mode=0, vme_bclr SHALL be active while any synchronized BR above arb_owner is active; it SHALL stay inactive in RRS mode.
REQ-024 In BUSY, when synchronized BBSY goes inactive, vme_bclr SHALL go inactive and the FSM SHALL enter RELEASE.
REQ-025 RELEASE SHALL last exactly one cycle, with all BG and BCLR inactive, then go to IDLE.
REQ-026 If BBSY is active while in IDLE (a foreign or pre-reset owner), the arbiter SHALL issue no grant until BBSY is inactive.
REQ-027 A change of arb_mode SHALL take effect at the next IDLE selection only.

Reset
REQ-028 While reset is low at a rising edge, the FSM SHALL go to IDLE; vme_bus_grant=4'b1111; vme_bclr=1; arb_owner=2'b00; arb_timeout=0; wait counter=0; synchronizers SHALL be set to inactive (1).
REQ-029 Reset asserted mid-grant or mid-busy SHALL deassert all outputs on that edge.
REQ-030 The first RRS selection after reset SHALL search 3,2,1,0.

Structure
REQ-031 ACTIVE/INACTIVE constants and the four state encodings SHALL live in the shared VME package, alongside the transfer and arbitration blocks' constants.
REQ-032 The two-flop synchronizer SHALL be the sub-module vme_sync2, parameterized by width and instantiated once for 5 bits.
REQ-033 The block SHALL be about 150-250 lines of RTL.

Verification
REQ-034 PRI: BR=4'b0101 (levels 3 and 1) with BBSY inactive -> BG3 active on the 3rd edge and arb_owner=3; BBSY driven low -> BG3 inactive one edge after synchronized BBSY.
REQ-035 PRI preemption: owner=1 and BUSY, BR3 asserted -> vme_bclr active within 3 edges; BBSY released -> BCLR inactive, RELEASE for one cycle, then BG3 granted.
REQ-036 RRS: all four BR held, each grant answered with BBSY for 5 cycles then released -> grant order 3,2,1,0,3.
REQ-037 Timeout: GRANT_TIMEOUT=8, BR0 held, BBSY never asserted -> BG0 active exactly 8 cycles, one arb_timeout pulse, RELEASE, then BG0 re-granted.
REQ-038 Corners: reset low during GRANT -> all BG=1 on that edge. BR withdrawn in GRANT -> no timeout pulse. BBSY and timeout in the same cycle -> state BUSY.
